prga_stage: RTL and testbench

PRGA_STAGE -- requirements
Module: prga_stage

---
 rtl/prga_stage.sv | 152 +++++++++++++++
 tb/tb_prga_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prga_stage.sv
// RC4 pseudo-random generation stage: decrypts a length-prefixed
// ciphertext buffer using the S permutation left by key scheduling.
module prga_stage (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  output logic [7:0] s_wrdata,
  input  logic [7:0] s_rddata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  typedef enum logic [3:0] {
    IDLE,
    RD_LEN,
    WR_LEN,
    RD_SI,
    RD_SJ,
    WR_SI,
    WR_SJ,
    RD_PAD,
    WR_PT,
    DONE
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic [7:0] si_q, si_d;
  logic [7:0] sj_q, sj_d;
  logic [7:0] len_q, len_d;
  logic [8:0] k_q, k_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
      len_q   <= 8'd0;
      k_q     <= 9'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      len_q   <= len_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    len_d   = len_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RD_LEN;
          i_d     = 8'd0;
          j_d     = 8'd0;
          k_d     = 9'd0;
        end
      end
      RD_LEN: state_d = WR_LEN;
      WR_LEN: begin
        len_d   = ct_rddata;
        state_d = (ct_rddata == 8'd0) ? DONE : RD_SI;
      end
      RD_SI: begin
        i_d     = i_q + 8'd1;
        k_d     = k_q + 9'd1;
        state_d = RD_SJ;
      end
      RD_SJ: begin
        si_d    = s_rddata;
        j_d     = j_q + s_rddata;
        state_d = WR_SI;
      end
      WR_SI: begin
        sj_d    = s_rddata;
        state_d = WR_SJ;
      end
      WR_SJ:  state_d = RD_PAD;
      RD_PAD: state_d = WR_PT;
      // k is 9 bits wide so L=255 terminates without wrap
      WR_PT: begin
        if (k_q < {1'b0, len_q}) state_d = RD_SI;
        else                     state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdy       = 1'b0;
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_wren    = 1'b0;
    ct_addr   = 8'd0;
    pt_addr   = 8'd0;
    pt_wrdata = 8'd0;
    pt_wren   = 1'b0;
    unique case (state_q)
      IDLE:   rdy = 1'b1;
      RD_LEN: ct_addr = 8'd0;
      WR_LEN: begin
        pt_addr   = 8'd0;
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
      end
      RD_SI: s_addr = i_q + 8'd1;
      RD_SJ: s_addr = j_q + s_rddata;
      WR_SI: begin
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
      end
      WR_SJ: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
      end
      // pad read follows both swap writes, so it sees post-swap S
      RD_PAD: begin
        s_addr  = si_q + sj_q;
        ct_addr = k_q[7:0];
      end
      WR_PT: begin
        pt_addr   = k_q[7:0];
        pt_wrdata = s_rddata ^ ct_rddata;
        pt_wren   = 1'b1;
      end
      DONE:    rdy = 1'b0;
      default: rdy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_prga_stage.sv
// Bench for prga_stage: memory models, RC4 reference model and
// an in-order scoreboard of expected plaintext writes.
module tb_prga_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr, s_wrdata, s_rddata;
  logic       s_wren;
  logic [7:0] ct_addr, ct_rddata;
  logic [7:0] pt_addr, pt_wrdata;
  logic       pt_wren;

  always #5 clk = ~clk;

  prga_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .s_addr    (s_addr),
    .s_wrdata  (s_wrdata),
    .s_rddata  (s_rddata),
    .s_wren    (s_wren),
    .ct_addr   (ct_addr),
    .ct_rddata (ct_rddata),
    .pt_addr   (pt_addr),
    .pt_wrdata (pt_wrdata),
    .pt_wren   (pt_wren)
  );

  logic [7:0]  smem   [256];
  logic [7:0]  s_img  [256];
  logic [7:0]  ct_img [256];
  logic [7:0]  pt_mem [256];
  logic [7:0]  mS     [256];
  logic        ld;
  logic [15:0] exp_q  [$];

  int checks;
  int failures;
  int hs;
  int s_cnt;
  int pt_cnt;
  bit sb_en;

  always @(posedge clk) begin
    if (ld) begin
      for (int n = 0; n < 256; n++) smem[n] <= s_img[n];
    end else if (s_wren) begin
      smem[s_addr] <= s_wrdata;
    end
    s_rddata  <= smem[s_addr];
    ct_rddata <= ct_img[ct_addr];
    if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [15:0] e;
    if (rdy && en && rst_n) hs++;
    @(negedge clk);
    if (s_wren) s_cnt++;
    if (pt_wren) begin
      pt_cnt++;
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_pt", {pt_addr, pt_wrdata}, 16'hxxxx);
        end else begin
          e = exp_q.pop_front();
          check("sb_pt", {pt_addr, pt_wrdata}, e);
        end
      end
    end
  endtask

  task automatic load_s();
    ld = 1'b1;
    tick();
    ld = 1'b0;
    for (int n = 0; n < 256; n++) mS[n] = s_img[n];
  endtask

  task automatic model_run();
    logic [7:0] i, j, si, sj, idx, pad;
    int len;
    len = int'(ct_img[0]);
    i = 8'd0;
    j = 8'd0;
    exp_q.push_back({8'h00, ct_img[0]});
    for (int k = 1; k <= len; k++) begin
      i = i + 8'd1;
      si = mS[i];
      j = j + si;
      sj = mS[j];
      mS[i] = sj;
      mS[j] = si;
      idx = si + sj;
      pad = mS[idx];
      exp_q.push_back({k[7:0], pad ^ ct_img[k]});
    end
  endtask

  task automatic pulse_en();
    en = 1'b1;
    tick();
    en = 1'b0;
    check("rdy_drop", {63'd0, rdy}, 64'd0);
  endtask

  task automatic wait_done(input int budget, input string tag,
                           output int cyc);
    cyc = 0;
    while (!rdy && cyc < budget) begin
      tick();
      cyc++;
    end
    check({tag, "_rdy_back"}, {63'd0, rdy}, 64'd1);
  endtask

  initial begin
    int c, s0, p0, h0, bad;
    bit seen [256];
    logic [7:0] t;
    int r;
    checks   = 0;
    failures = 0;
    hs       = 0;
    s_cnt    = 0;
    pt_cnt   = 0;
    sb_en    = 1'b1;
    ld       = 1'b0;
    en       = 1'b0;
    rst_n    = 1'b0;
    for (int n = 0; n < 256; n++) begin
      s_img[n]  = 8'(n);
      ct_img[n] = 8'd0;
    end

    // reset state
    repeat (3) tick();
    check("rst_rdy", {63'd0, rdy}, 64'd1);
    check("rst_outs",
          {22'd0, s_addr, s_wrdata, ct_addr, pt_addr, pt_wrdata,
           s_wren, pt_wren}, 64'd0);
    en = 1'b1;
    tick();
    en = 1'b0;
    rst_n = 1'b1;
    repeat (5) tick();
    check("post_rst_idle", {63'd0, rdy}, 64'd1);
    check("post_rst_no_wr", {32'(s_cnt), 32'(pt_cnt)}, 64'd0);

    // identity S, two-byte message
    ct_img[0] = 8'd2;
    ct_img[1] = 8'h41;
    ct_img[2] = 8'h42;
    load_s();
    model_run();
    p0 = pt_cnt;
    pulse_en();
    wait_done(60, "l2", c);
    check("l2_pt_count", 64'(pt_cnt - p0), 64'd3);
    check("l2_sb_drain", 64'(exp_q.size()), 64'd0);
    check("l2_pt_bytes", {40'd0, pt_mem[0], pt_mem[1], pt_mem[2]},
          64'h02_43_47);
    check("l2_s_swap", {48'd0, smem[2], smem[3]}, 64'h03_02);

    // zero-length message
    ct_img[0] = 8'd0;
    load_s();
    model_run();
    p0 = pt_cnt;
    s0 = s_cnt;
    pulse_en();
    wait_done(5, "l0", c);
    check("l0_pt_count", 64'(pt_cnt - p0), 64'd1);
    check("l0_no_s_wr", 64'(s_cnt - s0), 64'd0);
    check("l0_pt0", {56'd0, pt_mem[0]}, 64'd0);

    // L=255 with a random permutation
    for (int n = 255; n > 0; n--) begin
      r = $urandom_range(n, 0);
      t = s_img[n];
      s_img[n] = s_img[r];
      s_img[r] = t;
    end
    ct_img[0] = 8'd255;
    for (int n = 1; n < 256; n++) ct_img[n] = 8'($urandom);
    load_s();
    model_run();
    p0 = pt_cnt;
    pulse_en();
    wait_done(3000, "l255", c);
    check("l255_latency_ok", {63'd0, c <= 3 + 10 * 255}, 64'd1);
    check("l255_pt_count", 64'(pt_cnt - p0), 64'd256);
    check("l255_sb_drain", 64'(exp_q.size()), 64'd0);
    bad = 0;
    for (int n = 0; n < 256; n++) seen[n] = 1'b0;
    for (int n = 0; n < 256; n++) begin
      seen[smem[n]] = 1'b1;
      if (smem[n] !== mS[n]) bad++;
    end
    for (int n = 0; n < 256; n++) if (!seen[n]) bad++;
    check("l255_s_final_perm", 64'(bad), 64'd0);

    // reset during the third byte's first swap write
    sb_en = 1'b0;
    for (int n = 0; n < 256; n++) s_img[n] = 8'(n);
    ct_img[0] = 8'd5;
    load_s();
    s0 = s_cnt;
    pulse_en();
    c = 0;
    while (s_cnt - s0 < 5 && c < 200) begin
      tick();
      c++;
    end
    check("abort_reached_wr_si", 64'(s_cnt - s0), 64'd5);
    rst_n = 1'b0;
    #1;
    check("abort_outs", {61'd0, s_wren, pt_wren, rdy}, 64'd1);
    s0 = s_cnt;
    p0 = pt_cnt;
    h0 = hs;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    check("abort_no_writes", {32'(s_cnt - s0), 32'(pt_cnt - p0)}, 64'd0);
    check("abort_no_start", {31'd0, rdy, 32'(hs - h0)}, 64'h1_0000_0000);
    exp_q.delete();
    sb_en = 1'b1;

    // en held high: two back-to-back runs
    for (int n = 0; n < 256; n++) s_img[n] = 8'(n);
    ct_img[0] = 8'd2;
    ct_img[1] = 8'h41;
    ct_img[2] = 8'h42;
    load_s();
    model_run();
    model_run();
    p0 = pt_cnt;
    h0 = hs;
    en = 1'b1;
    c = 0;
    while (hs - h0 < 2 && c < 200) begin
      tick();
      c++;
    end
    en = 1'b0;
    check("hold_two_starts", 64'(hs - h0), 64'd2);
    wait_done(60, "hold", c);
    check("hold_no_third", 64'(hs - h0), 64'd2);
    check("hold_pt_count", 64'(pt_cnt - p0), 64'd6);
    check("hold_sb_drain", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
